// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   - state encoding for the converter FSM
//   - nibble adjust constants used by the shift-and-add-3 step
//   - clog2 helper used to size the bit counter
package bcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_e;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Ceiling log2, with a floor of 1 so a counter is never zero bits wide.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int x = value - 1; x > 0; x = x >> 1) begin
            res = res + 1;
        end
        if (res < 1) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit pre-shift correction: digits of 5 or more get +3 so that the
// following left shift carries correctly into the next decimal digit.
// Ports:
//   digit_i  4-bit BCD digit before adjust
//   digit_o  4-bit adjusted digit (max 12, never wraps)
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? (digit_i + BCD_ADJ_ADD) : digit_i;

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle IN_W-bit binary to DIGITS-digit BCD converter (double dabble),
// one shift per clock, with start/done handshake and a sticky overflow flag.
//
// state | meaning
// IDLE  | waiting for start; bin_in is captured on the accepting edge
// SHIFT | one adjust+shift per cycle, cnt counts remaining bits down to 1
// DONE  | one-cycle done pulse, results already registered
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    conversion request, honoured only in IDLE
//   bin_in   unsigned binary value, sampled when start is accepted
//   busy     high whenever the FSM is not IDLE
//   done     one-cycle pulse, bcd_out/ovf valid from this cycle
//   bcd_out  packed BCD result, digit 0 in [3:0]; held until the next done
//   ovf      value did not fit in DIGITS digits; bcd_out is value mod 10^DIGITS
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int IN_W   = 14,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = clog2(IN_W + 1);

    state_e          state_q, state_d;
    logic [IN_W-1:0] sr_q, sr_d;
    logic [BW-1:0]   acc_q, acc_d, acc_adj;
    logic            ovf_acc_q, ovf_acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (acc_q[4*g +: 4]),
            .digit_o (acc_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sr_d      = bin_in;
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CW'(IN_W);
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // The bin_sr MSB enters digit 0; the top digit's MSB falls off
                // the end and, if set, marks the result as overflowed.
                acc_d     = {acc_adj[BW-2:0], sr_q[IN_W-1]};
                sr_d      = sr_q << 1;
                ovf_acc_d = ovf_acc_q | acc_adj[BW-1];
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    bcd_d   = acc_d;
                    ovf_d   = ovf_acc_d;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Bench for bcd_seq_converter: three instances (14/5, 7/2, 10/4) checked every
// cycle against a transaction-level model, plus literal expectations.
module tb_bcd_seq_converter;

    localparam int INW [3] = '{14, 7, 10};
    localparam int DG  [3] = '{5, 2, 4};

    logic        clk = 1'b0;
    logic [2:0]  rst_v;
    logic [2:0]  start_v;
    logic [31:0] bin_v [3];
    logic [2:0]  busy_v, done_v, ovf_v;
    logic [19:0] bcd0;
    logic [7:0]  bcd1;
    logic [15:0] bcd2;
    logic [39:0] bcd_x [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_seq_converter #(.IN_W(14), .DIGITS(5)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .bin_in(bin_v[0][13:0]),
        .busy(busy_v[0]), .done(done_v[0]), .bcd_out(bcd0), .ovf(ovf_v[0]));
    bcd_seq_converter #(.IN_W(7), .DIGITS(2)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .bin_in(bin_v[1][6:0]),
        .busy(busy_v[1]), .done(done_v[1]), .bcd_out(bcd1), .ovf(ovf_v[1]));
    bcd_seq_converter #(.IN_W(10), .DIGITS(4)) u_dut2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .bin_in(bin_v[2][9:0]),
        .busy(busy_v[2]), .done(done_v[2]), .bcd_out(bcd2), .ovf(ovf_v[2]));

    always_comb begin
        bcd_x[0] = 40'(bcd0);
        bcd_x[1] = 40'(bcd1);
        bcd_x[2] = 40'(bcd2);
    end

    // Decimal split of v into d digits (implicitly modulo 10^d).
    function automatic logic [39:0] to_bcd(input longint v, input int d);
        logic [39:0] r;
        longint x;
        r = '0;
        x = v;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic longint pow10(input int d);
        longint p;
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        return p;
    endfunction

    // Transaction model: rem = busy cycles left (IN_W+1 after acceptance),
    // done is the last of them, results update as done rises.
    longint      m_val [3];
    int          m_rem [3] = '{0, 0, 0};
    logic [39:0] m_bcd [3] = '{40'd0, 40'd0, 40'd0};
    logic        m_ovf [3] = '{1'b0, 1'b0, 1'b0};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_v[i]) begin
                m_rem[i] = 0;
                m_bcd[i] = '0;
                m_ovf[i] = 1'b0;
            end else if (m_rem[i] == 0) begin
                if (start_v[i]) begin
                    m_rem[i] = INW[i] + 1;
                    m_val[i] = longint'(bin_v[i]) & ((64'sd1 <<< INW[i]) - 1);
                end
            end else begin
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 1) begin
                    m_bcd[i] = to_bcd(m_val[i], DG[i]);
                    m_ovf[i] = (m_val[i] >= pow10(DG[i]));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                checks = checks + 4;
                if (busy_v[i] !== (m_rem[i] != 0)) begin
                    errors = errors + 1;
                    $display("FAIL busy[%0d] cyc=%0d got %b want %b", i, cyc, busy_v[i], (m_rem[i] != 0));
                end
                if (done_v[i] !== (m_rem[i] == 1)) begin
                    errors = errors + 1;
                    $display("FAIL done[%0d] cyc=%0d got %b want %b", i, cyc, done_v[i], (m_rem[i] == 1));
                end
                if (bcd_x[i] !== m_bcd[i]) begin
                    errors = errors + 1;
                    $display("FAIL bcd_out[%0d] cyc=%0d got %h want %h", i, cyc, bcd_x[i], m_bcd[i]);
                end
                if (ovf_v[i] !== m_ovf[i]) begin
                    errors = errors + 1;
                    $display("FAIL ovf[%0d] cyc=%0d got %b want %b", i, cyc, ovf_v[i], m_ovf[i]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    // Start one conversion at the next falling edge; returns the result seen
    // when done rises and the latency in cycles. start/bin_in are scrambled
    // while busy to show they are ignored.
    task automatic run_conv(input int i, input logic [31:0] v,
                            output logic [39:0] res, output logic ov, output int lat);
        @(negedge clk);
        start_v[i] = 1'b1;
        bin_v[i]   = v;
        lat = 0;
        res = '0;
        ov  = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done_v[i]) begin
                lat = n;
                res = bcd_x[i];
                ov  = ovf_v[i];
                start_v[i] = 1'b0;
                break;
            end
            start_v[i] = 1'($urandom % 2);
            bin_v[i]   = $urandom;
        end
        if (lat == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            start_v[i] = 1'b0;
            $display("FAIL timeout[%0d] got no done want done within 100 cycles", i);
        end
    endtask

    initial begin
        logic [39:0] res;
        logic        ov;
        int          lat;
        int          prev_cyc;
        int          ndone;
        logic [31:0] vals [4];
        logic [39:0] exps [4];

        rst_v   = 3'b111;
        start_v = 3'b000;
        for (int i = 0; i < 3; i++) bin_v[i] = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_bcd0", 64'(bcd0), 64'h0);
        chk("reset_busy", 64'(busy_v), 64'h0);
        rst_v = 3'b000;

        // 99 on the 7-bit/2-digit instance: done in cycle 8
        run_conv(1, 32'd99, res, ov, lat);
        chk("c99_bcd", 64'(res), 64'h99);
        chk("c99_ovf", 64'(ov), 64'h0);
        chk("c99_lat", 64'(lat), 64'd8);

        // Back-to-back at the earliest accepted starts on the default instance
        vals = '{32'd16383, 32'd0, 32'd1, 32'd10000};
        exps = '{40'h16383, 40'h00000, 40'h00001, 40'h10000};
        prev_cyc = -1;
        for (int k = 0; k < 4; k++) begin
            run_conv(0, vals[k], res, ov, lat);
            chk("b2b_bcd", 64'(res), 64'(exps[k]));
            chk("b2b_ovf", 64'(ov), 64'h0);
            chk("b2b_lat", 64'(lat), 64'd15);
            if (prev_cyc >= 0) chk("b2b_spacing", 64'(cyc - prev_cyc), 64'd16);
            prev_cyc = cyc;
        end

        // Overflow sets, then clears on the next conversion
        run_conv(1, 32'd127, res, ov, lat);
        chk("c127_bcd", 64'(res), 64'h27);
        chk("c127_ovf", 64'(ov), 64'h1);
        run_conv(1, 32'd42, res, ov, lat);
        chk("c42_bcd", 64'(res), 64'h42);
        chk("c42_ovf", 64'(ov), 64'h0);

        // start held high, bin_in changing every cycle
        prev_cyc = -1;
        ndone = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (done_v[0]) begin
                if (prev_cyc >= 0) chk("held_spacing", 64'(cyc - prev_cyc), 64'd16);
                prev_cyc = cyc;
                ndone = ndone + 1;
            end
            start_v[0] = 1'b1;
            bin_v[0]   = $urandom;
        end
        chk("held_count_ge4", 64'(ndone >= 4), 64'h1);
        start_v[0] = 1'b0;
        repeat (20) @(negedge clk);

        // Reset during the 5th SHIFT cycle aborts the conversion
        start_v[0] = 1'b1;
        bin_v[0]   = 32'd1234;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
        end
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        chk("abort_busy", 64'(busy_v[0]), 64'h0);
        chk("abort_bcd", 64'(bcd0), 64'h0);
        chk("abort_ovf", 64'(ovf_v[0]), 64'h0);
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done_v[0]) ndone = ndone + 1;
        end
        chk("abort_no_done", 64'(ndone), 64'h0);
        run_conv(0, 32'd255, res, ov, lat);
        chk("c255_bcd", 64'(res), 64'h00255);

        // Exhaustive sweep of the 10-bit/4-digit instance
        for (int v = 0; v < 1024; v++) begin
            run_conv(2, 32'(v), res, ov, lat);
            chk("sweep_bcd", 64'(res),
                64'(((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10)));
            chk("sweep_ovf", 64'(ov), 64'h0);
        end

        // Random conversions with random idle gaps on the default instance
        for (int k = 0; k < 40; k++) begin
            int unsigned v;
            v = $urandom_range(0, 16383);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_conv(0, v, res, ov, lat);
            chk("rand_bcd", 64'(res), 64'(to_bcd(longint'(v), 5)));
            chk("rand_lat", 64'(lat), 64'd15);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
